sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce_pkg.sv | 13 +
 rtl/sw_debounce_db_bit.sv | 67 ++++++
 rtl/sw_debounce.sv | 51 +++++
 3 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and sizing helper for the slide-switch debouncer.
package sw_pkg;

  localparam int SW_WIDTH         = 16;
  localparam int TICK_DIV_DEF     = 100000;
  localparam int STABLE_TICKS_DEF = 10;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_debounce_db_bit.sv
// One debounced switch bit: synchronizer, stability counter, accepted level and
// optional edge pulses (enabled by SW_DEBOUNCE_EDGE_EN).
module sw_db_bit
  import sw_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int                CW       = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      // Synchronizer stage: s2 is the only copy of the pin used below.
      s1 <= sw;
      s2 <= s1;
      // Stability stage: any agreement with db discards accumulated progress.
      if (s2 == db) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          db  <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  logic accept;
  assign accept = tick && (s2 != db) && (cnt == CNT_LAST);

  // Edge stage: pulses fire on the same edge db changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & s2;
      fall <= accept & ~s2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Slide-switch debouncer: shared sample tick plus WIDTH independent bit cells.
// Define SW_DEBOUNCE_EDGE_EN to generate sw_rise/sw_fall pulses.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] db_sw,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int            TW        = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  // With TICK_DIV=1 the count stays at zero and tick is permanently high.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_db_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .sw   (sw[i]),
      .db   (db_sw[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule
